// File: rtl/dw_hs_src.sv
// dw_hs_src: source-clock half of a 4-phase req/ack handshake crossing.
//
// Accepts one word per send while idle, holds it on data_s, raises req_s and
// completes the cycle against ack_d. ack_d is synchronized into clk_s before
// any decision is taken on it.
//
// Parameters:
//   width       data word width
//   f_sync_type flop stages on the ack_d synchronizer (2..4)
//   tmo_cycles  handshake-phase timeout in cycles (timeout build only)
//
// Ports:
//   clk_s    source clock
//   rst_s    synchronous active-high reset
//   init_s_n synchronous active-low soft clear, same effect as rst_s
//   send     transfer request, honoured only while busy is low
//   data_in  word to transfer
//   busy     handshake in progress or ack still high
//   req_s    request to destination
//   data_s   registered word, stable while req_s is high
//   ack_d    asynchronous acknowledge from destination
//   done     one-cycle pulse on handshake completion
//   err      one-cycle pulse on timeout abort (0 when timeout not built)
//
// Build option: define DW_HS_SRC_TIMEOUT_EN to abort REQ/REL phases that stall
// for tmo_cycles-1 cycles.

module dw_hs_src #(
  parameter int unsigned width       = 8,
  parameter int unsigned f_sync_type = 2,
  parameter int unsigned tmo_cycles  = 256
) (
  input  logic             clk_s,
  input  logic             rst_s,
  input  logic             init_s_n,
  input  logic             send,
  input  logic [width-1:0] data_in,
  output logic             busy,
  output logic             req_s,
  output logic [width-1:0] data_s,
  input  logic             ack_d,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StRel
  } state_e;

  state_e                 state_q, state_d;
  logic                   req_q, req_d;
  logic [width-1:0]       data_q, data_d;
  logic                   done_q, done_d;
  logic [f_sync_type-1:0] sync_q, sync_d;
  logic                   clr;
  logic                   ack_sync;

  // Both clears behave identically; rst_s priority is moot since effects match.
  assign clr      = rst_s | ~init_s_n;
  assign sync_d   = {sync_q[f_sync_type-2:0], ack_d};
  assign ack_sync = sync_q[f_sync_type-1];

`ifdef DW_HS_SRC_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(tmo_cycles);
  localparam logic [CntW-1:0] TmoLast = CntW'(tmo_cycles - 1);

  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            tmo_hit;
  logic            err_q, err_d;

  assign cnt_inc = cnt_q + CntW'(1);
  // Abort on the edge where the counter would reach tmo_cycles-1.
  assign tmo_hit = (cnt_inc == TmoLast);
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    done_d  = 1'b0;
`ifdef DW_HS_SRC_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (send && !ack_sync) begin
          data_d  = data_in;
          req_d   = 1'b1;
          state_d = StReq;
`ifdef DW_HS_SRC_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      StReq: begin
        if (ack_sync) begin
          req_d   = 1'b0;
          state_d = StRel;
`ifdef DW_HS_SRC_TIMEOUT_EN
          cnt_d   = '0;
        end else if (tmo_hit) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_inc;
`endif
        end
      end
      StRel: begin
        if (!ack_sync) begin
          done_d  = 1'b1;
          state_d = StIdle;
`ifdef DW_HS_SRC_TIMEOUT_EN
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_inc;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_s) begin
    if (clr) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      done_q  <= done_d;
      sync_q  <= sync_d;
    end
  end

`ifdef DW_HS_SRC_TIMEOUT_EN
  always_ff @(posedge clk_s) begin
    if (clr) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy   = (state_q != StIdle) | ack_sync;
  assign req_s  = req_q;
  assign data_s = data_q;
  assign done   = done_q;

endmodule
